// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller that sequences an external combinational 16-bit ALU.
// It accepts one decoded instruction per valid/ready handshake and reads its
// operands from an internal register file. It presents the operands and opcode
// to the ALU. It then writes the result back and keeps a persistent flag
// register, so WAIT and CMP can hold or update flags independently of the
// register write.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   instr_valid/ready     instruction handshake
//   instr_opcode/rdest/rsrc/imm  decoded instruction fields
//   alu_a/alu_b/alu_opcode       registered ALU operand and opcode drive
//   alu_result/alu_flags         ALU outputs ({L,C,F,Z,N})
//   flags_q               architectural flag register
//   done/illegal          one-cycle retirement pulses
//   dbg_addr/dbg_data     combinational register-file read port
module alu_op_sequencer #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [7:0]        instr_opcode,
    input  logic [ADDR_W-1:0] instr_rdest,
    input  logic [ADDR_W-1:0] instr_rsrc,
    input  logic [7:0]        instr_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [7:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [4:0]        alu_flags,
    output logic [4:0]        flags_q,
    output logic              done,
    output logic              illegal,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int unsigned OP_W   = 8;
    localparam int unsigned IMM_W  = 8;
    localparam int unsigned FLAG_W = 5;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    typedef struct packed {
        logic [OP_W-1:0]   opcode;
        logic [ADDR_W-1:0] rdest;
        logic [ADDR_W-1:0] rsrc;
        logic [IMM_W-1:0]  imm;
    } instr_t;

    state_t              state_q, state_d;
    instr_t              instr_q, instr_d;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [DATA_W-1:0]   result_q, result_d;
    logic [FLAG_W-1:0]   flags_cap_q, flags_cap_d;
    logic [DATA_W-1:0]   alu_a_d, alu_b_d;
    logic [OP_W-1:0]     alu_opcode_d;
    logic                ready_d, done_d, illegal_d;
    logic                reg_we, flags_we;

    // Decode of the captured opcode.
    logic                is_imm, is_legal, is_wait, is_cmp, is_zext;
    logic [DATA_W-1:0]   imm_ext;

    always_comb begin
        is_imm   = (instr_q.opcode[3:0] == 4'h0) && (instr_q.opcode[7:4] != 4'h0);
        // Register forms occupy 0x00-0x0F; immediate forms start at 0x50.
        is_legal = (instr_q.opcode[7:4] == 4'h0) || (is_imm && (instr_q.opcode[7:4] >= 4'h5));
        is_wait  = (instr_q.opcode == 8'h00);
        is_cmp   = (instr_q.opcode == 8'h0B) || (instr_q.opcode == 8'hB0);
        is_zext  = (instr_q.opcode == 8'h60) || (instr_q.opcode == 8'h70) ||
                   (instr_q.opcode == 8'h80) || (instr_q.opcode == 8'hC0) ||
                   (instr_q.opcode == 8'hF0);
        imm_ext  = is_zext ? DATA_W'(instr_q.imm)
                           : {{(DATA_W-IMM_W){instr_q.imm[IMM_W-1]}}, instr_q.imm};
    end

    // Next-state and registered-output values.
    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        result_d     = result_q;
        flags_cap_d  = flags_cap_q;
        alu_a_d      = alu_a;
        alu_b_d      = alu_b;
        alu_opcode_d = alu_opcode;
        done_d       = 1'b0;
        illegal_d    = 1'b0;
        reg_we       = 1'b0;
        flags_we     = 1'b0;

        case (state_q)
            IDLE: begin
                if (instr_valid && instr_ready) begin
                    instr_d = '{opcode: instr_opcode, rdest: instr_rdest,
                                rsrc: instr_rsrc, imm: instr_imm};
                    state_d = READ;
                end
            end
            READ: begin
                alu_a_d      = regs[instr_q.rdest];
                alu_b_d      = is_imm ? imm_ext : regs[instr_q.rsrc];
                alu_opcode_d = instr_q.opcode;
                state_d      = EXEC;
            end
            EXEC: begin
                result_d    = alu_result;
                flags_cap_d = alu_flags;
                done_d      = 1'b1;
                illegal_d   = !is_legal;
                state_d     = WB;
            end
            WB: begin
                reg_we       = is_legal && !is_wait && !is_cmp;
                flags_we     = is_legal && !is_wait;
                alu_opcode_d = '0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    // State, datapath and register-file update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            instr_q     <= '0;
            result_q    <= '0;
            flags_cap_q <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_opcode  <= '0;
            flags_q     <= '0;
            done        <= 1'b0;
            illegal     <= 1'b0;
            instr_ready <= 1'b1;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            result_q    <= result_d;
            flags_cap_q <= flags_cap_d;
            alu_a       <= alu_a_d;
            alu_b       <= alu_b_d;
            alu_opcode  <= alu_opcode_d;
            done        <= done_d;
            illegal     <= illegal_d;
            instr_ready <= ready_d;
            if (reg_we) begin
                regs[instr_q.rdest] <= result_q;
            end
            if (flags_we) begin
                flags_q <= flags_cap_q;
            end
        end
    end

    // Debug read port, no bypass of a same-cycle write.
    assign dbg_data = regs[dbg_addr];

endmodule
